vector_seq_divider: RTL
=======================

VECTOR_SEQ_DIVIDER -- requirements
Module: vector_seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: bits per lane.
REQ-002 The block SHALL have parameter LANES, default 8: number of independent lanes.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operand vectors present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 The block SHALL have port operand1, input, [LANES-1:0][WIDTH-1:0]: dividend per lane.
REQ-008 The block SHALL have port operand2, input, [LANES-1:0][WIDTH-1:0]: divisor per lane.
REQ-009 The block SHALL have port out_valid, output, 1 bit: results valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer takes results.
REQ-011 The block SHALL have port quotient, output, [LANES-1:0][WIDTH-1:0]: per-lane quotient.
REQ-012 The block SHALL have port remainder, output, [LANES-1:0][WIDTH-1:0]: per-lane remainder.
REQ-013 The block SHALL have ports V, N and Z, each output, [LANES-1:0]: per-lane flags (V = divide-by-zero or overflow, N = quotient MSB, Z = quotient zero).

Function
REQ-014 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; a transfer SHALL occur when in_valid and in_ready are both 1 on a rising edge.
REQ-016 On a transfer, the block SHALL latch both operand vectors, clear the iteration counter and enter RUN; operand inputs SHALL be ignored outside a transfer.
REQ-017 In RUN, all lanes SHALL perform one restoring-division step per cycle in parallel, one quotient bit per step, MSB first.
REQ-018 The FSM SHALL leave RUN for DONE after exactly WIDTH steps; out_valid SHALL first be 1 in the cycle after the WIDTH+1th rising edge following the transfer edge.
REQ-019 In DONE, out_valid SHALL be 1 and quotient, remainder, V, N and Z SHALL be held stable until out_ready is 1 on a rising edge; that edge SHALL return the FSM to IDLE.
REQ-020 The block SHALL never accept a new transfer in the cycle that DONE is consumed; the next transfer SHALL be possible at the earliest one cycle later, in IDLE.
REQ-021 In the default (unsigned) mode, quotient SHALL be floor(op1/op2) and remainder SHALL be op1 mod op2.
REQ-022 For a divisor of 0, the lane SHALL produce a quotient of all ones and remainder = dividend, with V=1; other lanes SHALL be unaffected.
REQ-023 Flags SHALL be computed from final lane results: N = quotient[WIDTH-1], Z = (quotient == 0); V SHALL be 0 except where REQ-022 or REQ-029 applies.
REQ-024 Results and flags SHALL be registered outputs; they SHALL hold their last values in IDLE and RUN and change only on the edge entering DONE.

Reset
REQ-025 rst=1 on a rising edge SHALL force IDLE and clear the counter and all operand registers.
REQ-026 Reset SHALL force out_valid=0, quotient=0, remainder=0, V=0, N=0 and Z=0; in_ready SHALL be 1 in the cycle after reset is released.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation with no output; the pending result SHALL be discarded.

Configuration
REQ-028 The macro VECTOR_SEQ_DIVIDER_SIGNED_EN SHALL select signed operation; when the macro is undefined, operation SHALL be unsigned per REQ-021 and the latency SHALL be unchanged in both modes.
REQ-029 With the macro defined, operands SHALL be two's complement and division SHALL be performed on the magnitudes:
- quotient truncates toward zero
- remainder takes the sign of the dividend
- divide-by-zero gives quotient -1 (all ones) and remainder = dividend, with V=1
- most-negative / -1 gives quotient = most-negative and remainder 0, with V=1

Verification
REQ-030 Unsigned case: lane0 200/7 -> quotient 28, remainder 4, V=0 N=0 Z=0; out_valid first 1 after 9 edges.
REQ-031 Divide-by-zero: lane3 55/0 with other lanes 10/3 -> lane3 quotient 0xFF, remainder 55, V=1; other lanes quotient 3, remainder 1.
REQ-032 Backpressure: out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-033 Reset mid-RUN: rst at step 4 -> out_valid=0 and all outputs 0 next cycle; a new 9/3 operation then gives quotient 3.
REQ-034 Signed (macro defined): -7/2 -> quotient -3, remainder -1; -128/-1 -> quotient -128, remainder 0, V=1, N=1.
REQ-035 Boundary: 0/5 -> quotient 0, Z=1; 255/1 -> quotient 255, N=1 (unsigned).

Source files
------------

// File: rtl/vector_seq_divider.sv
// Multi-lane sequential restoring divider: one quotient bit per lane per cycle, MSB first.
// Define VECTOR_SEQ_DIVIDER_SIGNED_EN for two's-complement operation; unsigned otherwise.
module vector_seq_divider #(
    parameter int WIDTH = 8,
    parameter int LANES = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES-1:0][WIDTH-1:0]  operand1,
    input  logic [LANES-1:0][WIDTH-1:0]  operand2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES-1:0][WIDTH-1:0]  quotient,
    output logic [LANES-1:0][WIDTH-1:0]  remainder,
    output logic [LANES-1:0]             V,
    output logic [LANES-1:0]             N,
    output logic [LANES-1:0]             Z
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
`ifdef VECTOR_SEQ_DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state_q,  state_d;
    logic [CNT_W-1:0]              cnt_q,    cnt_d;
    logic [LANES-1:0][WIDTH-1:0]   op1_q,    op1_d;
    logic [LANES-1:0][WIDTH-1:0]   op2_q,    op2_d;
    logic [LANES-1:0][WIDTH-1:0]   acc_q,    acc_d;
    logic [LANES-1:0][WIDTH-1:0]   quo_q,    quo_d;
    logic [LANES-1:0][WIDTH-1:0]   q_res_q,  q_res_d;
    logic [LANES-1:0][WIDTH-1:0]   r_res_q,  r_res_d;
    logic [LANES-1:0]              v_q,      v_d;
    logic [LANES-1:0]              n_q,      n_d;
    logic [LANES-1:0]              z_q,      z_d;

`ifdef VECTOR_SEQ_DIVIDER_SIGNED_EN
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        negate = ~v + ONE;
    endfunction

    // The most-negative value maps onto itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        magnitude = v[WIDTH-1] ? negate(v) : v;
    endfunction
`else
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        magnitude = v;
    endfunction
`endif

    logic [WIDTH+1:0] trial_s;
    logic [WIDTH-1:0] dvs_s;
    logic [WIDTH-1:0] qv_s;
    logic [WIDTH-1:0] rv_s;
    logic             ovf_s;

    // Next-state, restoring-division step and result finalisation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        acc_d   = acc_q;
        quo_d   = quo_q;
        q_res_d = q_res_q;
        r_res_d = r_res_q;
        v_d     = v_q;
        n_d     = n_q;
        z_d     = z_q;
        trial_s = {(WIDTH+2){1'b0}};
        dvs_s   = ALL_ZERO;
        qv_s    = ALL_ZERO;
        rv_s    = ALL_ZERO;
        ovf_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op1_d   = operand1;
                    op2_d   = operand2;
                    cnt_d   = {CNT_W{1'b0}};
                    for (int i = 0; i < LANES; i++) begin
                        acc_d[i] = ALL_ZERO;
                        quo_d[i] = magnitude(operand1[i]);
                    end
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                if (cnt_q != CNT_LAST) begin
                    // quo_q shifts dividend bits out at the top and quotient bits in at the bottom.
                    for (int i = 0; i < LANES; i++) begin
                        dvs_s   = magnitude(op2_q[i]);
                        trial_s = {1'b0, acc_q[i], quo_q[i][WIDTH-1]} - {2'b00, dvs_s};
                        if (!trial_s[WIDTH+1]) begin
                            acc_d[i] = trial_s[WIDTH-1:0];
                        end else begin
                            acc_d[i] = {acc_q[i][WIDTH-2:0], quo_q[i][WIDTH-1]};
                        end
                        quo_d[i] = {quo_q[i][WIDTH-2:0], ~trial_s[WIDTH+1]};
                    end
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    for (int i = 0; i < LANES; i++) begin
`ifdef VECTOR_SEQ_DIVIDER_SIGNED_EN
                        qv_s  = (op1_q[i][WIDTH-1] ^ op2_q[i][WIDTH-1]) ? negate(quo_q[i]) : quo_q[i];
                        rv_s  = op1_q[i][WIDTH-1] ? negate(acc_q[i]) : acc_q[i];
                        ovf_s = (op1_q[i] == MOST_NEG) && (op2_q[i] == ALL_ONES);
`else
                        qv_s  = quo_q[i];
                        rv_s  = acc_q[i];
                        ovf_s = 1'b0;
`endif
                        if (op2_q[i] == ALL_ZERO) begin
                            qv_s   = ALL_ONES;
                            rv_s   = op1_q[i];
                            v_d[i] = 1'b1;
                        end else begin
                            v_d[i] = ovf_s;
                        end
                        q_res_d[i] = qv_s;
                        r_res_d[i] = rv_s;
                        n_d[i]     = qv_s[WIDTH-1];
                        z_d[i]     = (qv_s == ALL_ZERO);
                    end
                    state_d = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            op1_q   <= {(LANES*WIDTH){1'b0}};
            op2_q   <= {(LANES*WIDTH){1'b0}};
            acc_q   <= {(LANES*WIDTH){1'b0}};
            quo_q   <= {(LANES*WIDTH){1'b0}};
            q_res_q <= {(LANES*WIDTH){1'b0}};
            r_res_q <= {(LANES*WIDTH){1'b0}};
            v_q     <= {LANES{1'b0}};
            n_q     <= {LANES{1'b0}};
            z_q     <= {LANES{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            acc_q   <= acc_d;
            quo_q   <= quo_d;
            q_res_q <= q_res_d;
            r_res_q <= r_res_d;
            v_q     <= v_d;
            n_q     <= n_d;
            z_q     <= z_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = q_res_q;
    assign remainder = r_res_q;
    assign V         = v_q;
    assign N         = n_q;
    assign Z         = z_q;

endmodule
